change_dispenser: RTL and testbench

- Payout side of the vending machine. Accepts a refund amount from the vending controller and ejects it as a sequence of coin pulses to the coin hopper.
- Coin pulses use the same coin/value convention as the coin-acceptance interface.
- Tracks a per-denomination coin inventory and pays greedily, largest coin first.
- Reports any amount it cannot pay, and a hopper fault if the hopper stops acknowledging.

---
 rtl/vending_pkg.sv | 31 +++
 rtl/change_select.sv | 40 ++++
 rtl/change_dispenser.sv | 156 +++++++++++++++
 tb/tb_change_dispenser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending machine payout path.
//   COIN1/COIN2/COIN5 : coin denominations (same values the coin acceptor uses)
//   PRICE             : product price
//   disp_state_t      : change dispenser FSM states
//   load_sel_t        : restock target encoding for load_sel
// ---------------------------------------------------------------------------
package vending_pkg;

   localparam int COIN1 = 1;
   localparam int COIN2 = 2;
   localparam int COIN5 = 5;
   localparam int PRICE = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_EJECT,
      ST_WAIT_ACK,
      ST_DONE
   } disp_state_t;

   typedef enum logic [1:0] {
      LOAD_C1   = 2'd0,
      LOAD_C2   = 2'd1,
      LOAD_C5   = 2'd2,
      LOAD_NONE = 2'd3
   } load_sel_t;

endpackage

// File: rtl/change_select.sv
// ---------------------------------------------------------------------------
// change_select
// Combinational greedy coin choice: the largest denomination that still fits
// in the remaining amount and is in stock. No backtracking.
// Ports:
//   remaining              in  amount still to pay
//   inv_c1/inv_c2/inv_c5   in  inventory of each denomination
//   found                  out a coin can be paid
//   d                      out chosen denomination (0 when found=0)
// ---------------------------------------------------------------------------
module change_select
   import vending_pkg::*;
#(
   parameter int AMT_W = 4,
   parameter int CNT_W = 4
) (
   input  logic [AMT_W-1:0] remaining,
   input  logic [CNT_W-1:0] inv_c1,
   input  logic [CNT_W-1:0] inv_c2,
   input  logic [CNT_W-1:0] inv_c5,
   output logic             found,
   output logic [AMT_W-1:0] d
);

   always_comb begin
      found = 1'b0;
      d     = '0;
      if (remaining >= AMT_W'(COIN5) && inv_c5 != '0) begin
         found = 1'b1;
         d     = AMT_W'(COIN5);
      end else if (remaining >= AMT_W'(COIN2) && inv_c2 != '0) begin
         found = 1'b1;
         d     = AMT_W'(COIN2);
      end else if (remaining >= AMT_W'(COIN1) && inv_c1 != '0) begin
         found = 1'b1;
         d     = AMT_W'(COIN1);
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays a refund as a sequence of coin pulses to the hopper, largest coin
// first, from a per-denomination inventory. Reports unpaid remainder
// (shortfall) and hopper acknowledge timeout (fault).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   refund_valid/amt  refund request (accepted only while ready)
//   ready             high in IDLE
//   coin_out/_value   one-cycle coin pulse and its denomination
//   hopper_ack        hopper confirms the last coin
//   load_en/sel/cnt   restock: replace one inventory count (IDLE only)
//   done              one-cycle completion pulse
//   shortfall, fault  result of the last request, held until the next one
// ---------------------------------------------------------------------------
module change_dispenser
   import vending_pkg::*;
#(
   parameter int AMT_W       = 4,
   parameter int CNT_W       = 4,
   parameter int INIT_CNT    = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             refund_valid,
   input  logic [AMT_W-1:0] refund_amt,
   output logic             ready,
   output logic             coin_out,
   output logic [AMT_W-1:0] coin_out_value,
   input  logic             hopper_ack,
   input  logic             load_en,
   input  logic [1:0]       load_sel,
   input  logic [CNT_W-1:0] load_cnt,
   output logic             done,
   output logic [AMT_W-1:0] shortfall,
   output logic             fault
);

   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

   disp_state_t      state, state_nxt;
   logic [AMT_W-1:0] remaining;
   logic [AMT_W-1:0] d_cur;
   logic [CNT_W-1:0] inv_c1, inv_c2, inv_c5;
   logic [WAIT_W-1:0] wait_cnt;
   logic             sel_found;
   logic [AMT_W-1:0] sel_d;
   logic             timeout;

   function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                                input logic [AMT_W-1:0] b);
      logic [AMT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[AMT_W] ? {AMT_W{1'b1}} : sum[AMT_W-1:0];
   endfunction

   change_select #(
      .AMT_W(AMT_W),
      .CNT_W(CNT_W)
   ) u_select (
      .remaining(remaining),
      .inv_c1   (inv_c1),
      .inv_c2   (inv_c2),
      .inv_c5   (inv_c5),
      .found    (sel_found),
      .d        (sel_d)
   );

   // Timeout fires on the last allowed ack-less cycle of WAIT_ACK.
   assign timeout = (state == ST_WAIT_ACK) && !hopper_ack &&
                    (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));

   always_comb begin
      state_nxt      = state;
      ready          = 1'b0;
      coin_out       = 1'b0;
      coin_out_value = '0;
      unique case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (refund_valid) state_nxt = ST_SELECT;
         end
         ST_SELECT:   state_nxt = sel_found ? ST_EJECT : ST_DONE;
         ST_EJECT: begin
            coin_out       = 1'b1;
            coin_out_value = d_cur;
            state_nxt      = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (hopper_ack)   state_nxt = ST_SELECT;
            else if (timeout) state_nxt = ST_DONE;
         end
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         remaining <= '0;
         d_cur     <= '0;
         inv_c1    <= CNT_W'(INIT_CNT);
         inv_c2    <= CNT_W'(INIT_CNT);
         inv_c5    <= CNT_W'(INIT_CNT);
         wait_cnt  <= '0;
         done      <= 1'b0;
         shortfall <= '0;
         fault     <= 1'b0;
      end else begin
         state <= state_nxt;
         // done is registered off the DONE state, so it appears the cycle after.
         done  <= (state == ST_DONE);
         unique case (state)
            ST_IDLE: begin
               // A restock in the same cycle as a request is visible to SELECT.
               if (load_en) begin
                  if (load_sel == LOAD_C1) inv_c1 <= load_cnt;
                  if (load_sel == LOAD_C2) inv_c2 <= load_cnt;
                  if (load_sel == LOAD_C5) inv_c5 <= load_cnt;
               end
               if (refund_valid) begin
                  remaining <= refund_amt;
                  shortfall <= '0;
                  fault     <= 1'b0;
               end
            end
            ST_SELECT: begin
               if (sel_found) d_cur     <= sel_d;
               else           shortfall <= remaining;
            end
            ST_EJECT: begin
               // change_select only picks stocked coins no larger than remaining.
               if (d_cur == AMT_W'(COIN5) && inv_c5 != '0) inv_c5 <= inv_c5 - CNT_W'(1);
               if (d_cur == AMT_W'(COIN2) && inv_c2 != '0) inv_c2 <= inv_c2 - CNT_W'(1);
               if (d_cur == AMT_W'(COIN1) && inv_c1 != '0) inv_c1 <= inv_c1 - CNT_W'(1);
               remaining <= remaining - d_cur;
               wait_cnt  <= '0;
            end
            ST_WAIT_ACK: begin
               if (timeout) begin
                  // Unacknowledged coin counts as unpaid; inventory stays
                  // decremented since the coin may be jammed in the hopper.
                  fault     <= 1'b1;
                  shortfall <= sat_add(remaining, d_cur);
               end else if (!hopper_ack) begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

   localparam int AMT_W = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             refund_valid;
   logic [AMT_W-1:0] refund_amt;
   logic             ready;
   logic             coin_out;
   logic [AMT_W-1:0] coin_out_value;
   logic             hopper_ack;
   logic             load_en;
   logic [1:0]       load_sel;
   logic [CNT_W-1:0] load_cnt;
   logic             done;
   logic [AMT_W-1:0] shortfall;
   logic             fault;

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;
   int done_n = 0;
   int done_cyc = 0;
   int coin_q[$];
   int coin_cyc[$];
   bit ack_en = 1'b1;
   bit pend = 1'b0;
   int nref;
   int qb;
   int db;

   change_dispenser #(
      .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_CNT(4), .ACK_TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .refund_valid(refund_valid), .refund_amt(refund_amt),
      .ready(ready), .coin_out(coin_out), .coin_out_value(coin_out_value),
      .hopper_ack(hopper_ack),
      .load_en(load_en), .load_sel(load_sel), .load_cnt(load_cnt),
      .done(done), .shortfall(shortfall), .fault(fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   // Cycle numbering: the cycle that ends at edge k is cycle k.
   always @(negedge clk) begin
      if (coin_out) begin
         coin_q.push_back(int'(coin_out_value));
         coin_cyc.push_back(ecnt + 1);
      end
      if (done) begin
         done_n   <= done_n + 1;
         done_cyc <= ecnt + 1;
      end
   end

   // Hopper model: acknowledges one cycle after each coin pulse.
   initial begin
      hopper_ack = 1'b0;
      forever begin
         @(negedge clk);
         hopper_ack = ack_en && pend;
         pend       = coin_out;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int sel, input int cnt);
      load_en  = 1'b1;
      load_sel = 2'(sel);
      load_cnt = CNT_W'(cnt);
      tick();
      load_en  = 1'b0;
   endtask

   task automatic start_refund(input int amt);
      qb = coin_q.size();
      db = done_n;
      refund_valid = 1'b1;
      refund_amt   = AMT_W'(amt);
      nref = ecnt + 1;
      tick();
      refund_valid = 1'b0;
      load_en      = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && done_n == db; i++) tick();
      if (done_n == db) chk("done_timeout", 0, 1);
      tick();
   endtask

   task automatic chk_inv(input string tag, input int c1, input int c2, input int c5);
      chk({tag, "_inv1"}, int'(dut.inv_c1), c1);
      chk({tag, "_inv2"}, int'(dut.inv_c2), c2);
      chk({tag, "_inv5"}, int'(dut.inv_c5), c5);
   endtask

   initial begin
      reset = 1'b1; refund_valid = 1'b0; refund_amt = '0;
      load_en = 1'b0; load_sel = '0; load_cnt = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_ready", int'(ready), 1);
      chk("rst_coin", int'(coin_out), 0);
      chk("rst_coinval", int'(coin_out_value), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_short", int'(shortfall), 0);
      chk("rst_fault", int'(fault), 0);
      chk_inv("rst", 4, 4, 4);

      // refund 8 from 3/3/3 -> 5,2,1
      load(0, 3); load(1, 3); load(2, 3);
      start_refund(8);
      wait_done();
      chk("t1_ncoin", coin_q.size() - qb, 3);
      if (coin_q.size() - qb == 3) begin
         chk("t1_c0", coin_q[qb], 5);
         chk("t1_c1", coin_q[qb+1], 2);
         chk("t1_c2", coin_q[qb+2], 1);
         chk("t1_lat_first", coin_cyc[qb] - nref, 2);
         chk("t1_lat_ack", coin_cyc[qb+1] - coin_cyc[qb], 3);
      end
      chk("t1_done_cyc", done_cyc - nref, 12);
      chk("t1_short", int'(shortfall), 0);
      chk("t1_fault", int'(fault), 0);
      chk_inv("t1", 2, 2, 2);

      // coin1 = 0, then coin2 = 0 together with refund 6 -> one 5, shortfall 1
      load(0, 0);
      load_en = 1'b1; load_sel = 2'd1; load_cnt = '0;
      start_refund(6);
      wait_done();
      chk("t2_ncoin", coin_q.size() - qb, 1);
      if (coin_q.size() > qb) chk("t2_c0", coin_q[qb], 5);
      chk("t2_short", int'(shortfall), 1);
      chk("t2_fault", int'(fault), 0);
      chk_inv("t2", 0, 0, 1);

      // coin1 = 3, refund 4 -> three 1s, inventory stops at 0, shortfall 1
      load(0, 3);
      start_refund(4);
      wait_done();
      chk("t3_ncoin", coin_q.size() - qb, 3);
      for (int i = qb; i < coin_q.size(); i++) chk("t3_val", coin_q[i], 1);
      chk("t3_short", int'(shortfall), 1);
      chk_inv("t3", 0, 0, 1);

      // coin5 = 0 loaded in the same cycle as refund 5 -> nothing payable
      load_en = 1'b1; load_sel = 2'd2; load_cnt = '0;
      start_refund(5);
      wait_done();
      chk("t3b_ncoin", coin_q.size() - qb, 0);
      chk("t3b_short", int'(shortfall), 5);
      load(3, 9);
      chk_inv("t3b_sel3", 0, 0, 0);

      // refund 7, no ack -> coin 5 then timeout
      load(0, 4); load(1, 4); load(2, 3);
      ack_en = 1'b0;
      start_refund(7);
      wait_done();
      chk("t4_ncoin", coin_q.size() - qb, 1);
      if (coin_q.size() > qb) begin
         chk("t4_c0", coin_q[qb], 5);
         chk("t4_tmo_cyc", done_cyc - coin_cyc[qb], 10);
      end
      chk("t4_fault", int'(fault), 1);
      chk("t4_short", int'(shortfall), 7);
      chk("t4_ready", int'(ready), 1);
      chk_inv("t4", 4, 4, 2);

      // inputs during WAIT_ACK ignored, then reset mid WAIT_ACK
      start_refund(2);
      chk("t5_fault_clr", int'(fault), 0);
      chk("t5_short_clr", int'(shortfall), 0);
      tick(); tick();
      refund_valid = 1'b1; refund_amt = 4'd5;
      load_en = 1'b1; load_sel = 2'd0; load_cnt = '0;
      tick();
      refund_valid = 1'b0; load_en = 1'b0;
      chk("t5_ready_busy", int'(ready), 0);
      chk_inv("t5_ign", 4, 3, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_ready", int'(ready), 1);
      chk_inv("t5_rst", 4, 4, 4);
      qb = coin_q.size();
      db = done_n;
      for (int i = 0; i < 20; i++) tick();
      chk("t5_no_coin", coin_q.size() - qb, 0);
      chk("t5_no_done", done_n - db, 0);

      // refund 0 -> no coin, done at N+3
      ack_en = 1'b1;
      start_refund(0);
      wait_done();
      chk("t6_ncoin", coin_q.size() - qb, 0);
      chk("t6_done_cyc", done_cyc - nref, 3);
      chk("t6_short", int'(shortfall), 0);
      chk("t6_fault", int'(fault), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
